cpu_seq: RTL
============

# cpu_seq

Multi-cycle instruction sequencer for the accumulator CPU. It turns the single-cycle datapath into a FETCH/EXEC machine with run, single-step and error control. It also stalls on INP until external data is valid and on OUT until the consumer is ready, with a watchdog on both waits. It sits between the control unit's decoded strobes and the write enables of PC, IR, ACC, INP, OUT and RAM.

## Interface
- WDOG_W, 8: watchdog counter width; wait limit is 2^WDOG_W cycles.

- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- run_i  in  1  level; free-running execution while high
- step_i  in  1  pulse; executes exactly one instruction when idle and run_i low
- ctrl_inp_i, ctrl_out_i, ctrl_mw_i, ctrl_alu_i, ctrl_imm_i  in  1 each  decoded strobes of the current IR
- in_valid_i  in  1  external input data valid
- out_ready_i  in  1  external consumer ready
- ir_we_o  out  1  latch instruction from ROM
- pc_en_o  out  1  PC updates (increment or branch) this cycle
- acc_we_o  out  1  ACC write
- mem_we_o  out  1  RAM write
- inp_we_o  out  1  INP register capture
- out_we_o  out  1  OUT register capture
- in_ready_o  out  1  ready for input beat
- out_valid_o  out  1  OUT register holds unconsumed data
- busy_o  out  1  state not IDLE and not ERR
- wdog_err_o  out  1  sticky watchdog error
- state_o  out  3  current state, debug

## Operation
- States: IDLE=0, FETCH=1, EXEC=2, WAIT_IN=3, WAIT_OUT=4, ERR=5. Values 6-7 are illegal and go to ERR.
- IDLE: if run_i or step_i, go to FETCH. Otherwise stay. step_i is ignored in all other states.
- FETCH: ir_we_o=1. Next state is EXEC.
- EXEC: ctrl_* are valid in this state.
  - ctrl_inp_i (has priority if ctrl_out_i is also set): go to WAIT_IN. No other strobes.
  - ctrl_out_i: out_we_o=1, then go to WAIT_OUT.
  - Otherwise the instruction completes: pc_en_o=1, acc_we_o=ctrl_alu_i|ctrl_imm_i, mem_we_o=ctrl_mw_i.
- WAIT_IN: in_ready_o=1. When in_valid_i is high, the instruction completes: inp_we_o=1, acc_we_o=1, pc_en_o=1.
- WAIT_OUT: out_valid_o=1. When out_ready_i is high, the instruction completes with pc_en_o=1.
- Completion: next state is FETCH if run_i is high, else IDLE.
- Watchdog:
  - The counter clears on entry to WAIT_IN or WAIT_OUT.
  - It increments on each wait cycle that has no handshake.
  - If count == 2^WDOG_W-1 and there is no handshake, go to ERR.
  - A handshake in the same cycle as the limit wins: the instruction completes and there is no error.
- ERR: wdog_err_o=1 and all strobes are 0. Only reset exits ERR.
- run_i falling mid-instruction: the current instruction finishes, then the machine returns to IDLE.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, counter 0, every output 0, state_o=0.
- Non-I/O instruction: 2 cycles (FETCH, EXEC). INP and OUT: 2 cycles plus the wait cycles; the minimum is 3 when the partner is already valid/ready.
- ir_we_o, in_ready_o, out_valid_o, busy_o, wdog_err_o and state_o depend on state only.
- pc_en_o, acc_we_o, mem_we_o, inp_we_o and out_we_o are combinational in state, ctrl_* and the handshake inputs.
- A handshake completes on the clock edge where valid&ready are both high. in_ready_o and out_valid_o drop the following cycle.
- Back-to-back instructions under run_i: EXEC/completion is followed immediately by FETCH, with no bubble.

## Structure
- The shared header cpu_defs.vh holds the state encodings (localparams), STATE_W=3 and the WDOG_W default.
- One sub-module, wait_timer: a WDOG_W-bit counter with clear, enable and a limit flag.
- The FSM and strobe decode live in cpu_seq.

## Test plan
- Reset, then run_i=1 with an ALU/IMM instruction: FETCH, EXEC; acc_we_o=1 and pc_en_o=1 in EXEC; FETCH follows in the next cycle.
- run_i=0, a step_i pulse, then an MW instruction: exactly one FETCH/EXEC; mem_we_o=1; back to IDLE with busy_o=0. A second step_i pulse during EXEC is ignored.
- INP with in_valid_i asserted 5 cycles after WAIT_IN entry: in_ready_o high for 6 cycles; inp_we_o, acc_we_o and pc_en_o pulse once, on the 6th cycle.
- OUT with out_ready_i already high: out_we_o in EXEC, out_valid_o for 1 cycle, pc_en_o in WAIT_OUT; 3 cycles total.
- WDOG_W=4, INP and in_valid_i never asserted: ERR after 16 WAIT_IN cycles; wdog_err_o sticky and all strobes 0 until rst_ni=0. Repeat with in_valid_i asserted on exactly the 16th cycle: the instruction completes with no error.
- rst_ni asserted mid WAIT_OUT: all outputs 0 immediately (asynchronously); after release, IDLE.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the accumulator CPU instruction sequencer.
//   state_e       : sequencer states; encodings 6-7 are illegal and recover to StErr.
//   StateW        : width of the state encoding exported on state_o.
//   WdogWDefault  : default watchdog counter width (wait limit is 2**WDOG_W cycles).
package cpu_seq_pkg;

  localparam int unsigned StateW       = 3;
  localparam int unsigned WdogWDefault = 8;

  typedef enum logic [StateW-1:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StExec    = 3'd2,
    StWaitIn  = 3'd3,
    StWaitOut = 3'd4,
    StErr     = 3'd5
  } state_e;

endpackage

// File: rtl/cpu_seq_wait_timer.sv
// Watchdog counter for the sequencer's I/O wait states.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   clr_i   : synchronous clear (has priority over en_i)
//   en_i    : count one wait cycle
//   limit_o : counter has reached 2**WDOG_W-1
module cpu_seq_wait_timer #(
  parameter int unsigned WDOG_W = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic limit_o
);

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_o = &cnt_q;

endmodule

// File: rtl/cpu_seq.sv
// Multi-cycle FETCH/EXEC sequencer for the accumulator CPU. Turns decoded control strobes
// into register write enables, stalls on INP/OUT handshakes and traps to a sticky error
// state when a wait exceeds the watchdog limit.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   run_i, step_i            : free-run level / single-instruction pulse (honoured in IDLE)
//   ctrl_{inp,out,mw,alu,imm}_i : decoded strobes of the current IR (valid in EXEC)
//   in_valid_i, out_ready_i  : external handshake partners
//   ir_we_o, pc_en_o, acc_we_o, mem_we_o, inp_we_o, out_we_o : datapath write enables
//   in_ready_o, out_valid_o  : handshake outputs (state-only)
//   busy_o, wdog_err_o, state_o : status (state-only)
module cpu_seq
  import cpu_seq_pkg::*;
#(
  parameter int unsigned WDOG_W = WdogWDefault
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              run_i,
  input  logic              step_i,
  input  logic              ctrl_inp_i,
  input  logic              ctrl_out_i,
  input  logic              ctrl_mw_i,
  input  logic              ctrl_alu_i,
  input  logic              ctrl_imm_i,
  input  logic              in_valid_i,
  input  logic              out_ready_i,
  output logic              ir_we_o,
  output logic              pc_en_o,
  output logic              acc_we_o,
  output logic              mem_we_o,
  output logic              inp_we_o,
  output logic              out_we_o,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic              busy_o,
  output logic              wdog_err_o,
  output logic [StateW-1:0] state_o
);

  state_e state_q, state_d;
  state_e done_state;
  logic   in_hs, out_hs, waiting, wdog_limit;

  assign in_hs      = (state_q == StWaitIn) && in_valid_i;
  assign out_hs     = (state_q == StWaitOut) && out_ready_i;
  assign waiting    = (state_q == StWaitIn) || (state_q == StWaitOut);
  // An instruction that completes while run_i has dropped parks the machine in IDLE.
  assign done_state = run_i ? StFetch : StIdle;

  // Cleared throughout EXEC so every wait starts from zero; counts only stalled wait cycles.
  cpu_seq_wait_timer #(
    .WDOG_W(WDOG_W)
  ) u_wait_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (state_q == StExec),
    .en_i   (waiting && !(in_hs || out_hs)),
    .limit_o(wdog_limit)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (run_i || step_i) state_d = StFetch;
      end
      StFetch: state_d = StExec;
      StExec: begin
        if (ctrl_inp_i) begin
          state_d = StWaitIn;
        end else if (ctrl_out_i) begin
          state_d = StWaitOut;
        end else begin
          state_d = done_state;
        end
      end
      StWaitIn: begin
        // A handshake on the limit cycle still completes the instruction.
        if (in_valid_i) begin
          state_d = done_state;
        end else if (wdog_limit) begin
          state_d = StErr;
        end
      end
      StWaitOut: begin
        if (out_ready_i) begin
          state_d = done_state;
        end else if (wdog_limit) begin
          state_d = StErr;
        end
      end
      StErr:   state_d = StErr;
      default: state_d = StErr;
    endcase
  end

  // Output decode.
  always_comb begin
    ir_we_o  = 1'b0;
    pc_en_o  = 1'b0;
    acc_we_o = 1'b0;
    mem_we_o = 1'b0;
    inp_we_o = 1'b0;
    out_we_o = 1'b0;
    case (state_q)
      StFetch: ir_we_o = 1'b1;
      StExec: begin
        if (ctrl_inp_i) begin
          // Nothing commits until the input beat arrives.
        end else if (ctrl_out_i) begin
          out_we_o = 1'b1;
        end else begin
          pc_en_o  = 1'b1;
          acc_we_o = ctrl_alu_i || ctrl_imm_i;
          mem_we_o = ctrl_mw_i;
        end
      end
      StWaitIn: begin
        inp_we_o = in_valid_i;
        acc_we_o = in_valid_i;
        pc_en_o  = in_valid_i;
      end
      StWaitOut: pc_en_o = out_ready_i;
      default: ;
    endcase
  end

  assign in_ready_o  = (state_q == StWaitIn);
  assign out_valid_o = (state_q == StWaitOut);
  assign busy_o      = (state_q == StFetch) || (state_q == StExec) ||
                       (state_q == StWaitIn) || (state_q == StWaitOut);
  assign wdog_err_o  = (state_q == StErr);
  assign state_o     = state_q;

endmodule
